posit_byte_io_seq: RTL and testbench

- Byte-serial front/back end for the 16-bit fixed-to-posit adder datapath.
- Collects two N-bit operands from an 8-bit valid/ready input stream and presents them as stable registered operands to the combinational add stage.
- Waits a programmable number of settle cycles, then captures the posit result.
- Returns the result on an 8-bit valid/ready output stream.

---
 rtl/posit_io_pkg.sv | 23 ++
 rtl/byte_shift_reg.sv | 55 +++++
 rtl/posit_byte_io_seq.sv | 145 ++++++++++++++
 tb/tb_posit_byte_io_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_io_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// posit_io_pkg : shared types and helpers for the posit byte-serial I/O block
// Revision: 1.0
// ============================================================================
package posit_io_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      CALC   = 2'd2,
      SEND   = 2'd3
   } state_t;

   function automatic int bytes_of(input int n);
      return n / BYTE_W;
   endfunction

endpackage
`default_nettype wire

// File: rtl/byte_shift_reg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// byte_shift_reg : N-bit register with byte shift-in/shift-out, parallel load
//                  and a flag marking the last byte position of a word
// Revision: 1.0
// ============================================================================
module byte_shift_reg
   import posit_io_pkg::*;
#(
   parameter int N = 16
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_shift_in,
   input  logic [BYTE_W-1:0] i_byte,
   input  logic              i_shift_out,
   input  logic              i_par_load,
   input  logic [N-1:0]      i_par_data,
   output logic [N-1:0]      o_word,
   output logic              o_last
);

   localparam int c_bytes = bytes_of(N);
   localparam int c_cnt_w = $clog2(c_bytes) + 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_bytes - 1);

   logic [N-1:0]       r_word;
   logic [c_cnt_w-1:0] r_cnt;
   logic               w_last;
   logic [BYTE_W-1:0]  w_fill;

   assign w_last = (r_cnt == c_cnt_last);
   // Shift-out pushes zeros in behind; only the top byte is ever observed.
   assign w_fill = i_shift_in ? i_byte : {BYTE_W{1'b0}};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_word <= '0;
         r_cnt  <= '0;
      end else if (i_par_load) begin
         r_word <= i_par_data;
         r_cnt  <= '0;
      end else if (i_shift_in || i_shift_out) begin
         r_word <= {r_word[N-BYTE_W-1:0], w_fill};
         r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_word = r_word;
   assign o_last = w_last;

endmodule
`default_nettype wire

// File: rtl/posit_byte_io_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// posit_byte_io_seq : collects two operands from a byte stream, waits for the
//                     add stage to settle, then streams the result back out
// Revision: 1.0
// ============================================================================
module posit_byte_io_seq
   import posit_io_pkg::*;
#(
   parameter int N           = 16,
   parameter int CALC_CYCLES = 1
)
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [BYTE_W-1:0] i_data,
   input  logic              i_valid,
   output logic              o_ready,
   output logic [BYTE_W-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [N-1:0]      o_op_1,
   output logic [N-1:0]      o_op_2,
   input  logic [N-1:0]      i_res,
   output logic              o_busy
);

   localparam int c_settle_w = $clog2(CALC_CYCLES) + 1;
   localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(CALC_CYCLES - 1);

   state_t                r_state;
   logic [c_settle_w-1:0] r_settle;
   logic                  r_ready;
   logic                  r_valid;
   logic                  r_busy;

   logic         w_accept;
   logic         w_op1_shift;
   logic         w_op2_shift;
   logic         w_op1_last;
   logic         w_op2_last;
   logic         w_res_load;
   logic         w_res_shift;
   logic         w_res_last;
   logic [N-1:0] w_res_word;

   // r_ready is only ever high in the two load states.
   assign w_accept    = i_valid && r_ready;
   assign w_op1_shift = w_accept && (r_state == LOAD_A);
   assign w_op2_shift = w_accept && (r_state == LOAD_B);
   assign w_res_load  = (r_state == CALC) && (r_settle == c_settle_last);
   assign w_res_shift = (r_state == SEND) && i_ready;

   byte_shift_reg #(.N(N)) u_op1 (
      .clk         (i_clk),
      .rst         (i_rst),
      .i_shift_in  (w_op1_shift),
      .i_byte      (i_data),
      .i_shift_out (1'b0),
      .i_par_load  (1'b0),
      .i_par_data  ({N{1'b0}}),
      .o_word      (o_op_1),
      .o_last      (w_op1_last)
   );

   byte_shift_reg #(.N(N)) u_op2 (
      .clk         (i_clk),
      .rst         (i_rst),
      .i_shift_in  (w_op2_shift),
      .i_byte      (i_data),
      .i_shift_out (1'b0),
      .i_par_load  (1'b0),
      .i_par_data  ({N{1'b0}}),
      .o_word      (o_op_2),
      .o_last      (w_op2_last)
   );

   byte_shift_reg #(.N(N)) u_res (
      .clk         (i_clk),
      .rst         (i_rst),
      .i_shift_in  (1'b0),
      .i_byte      ({BYTE_W{1'b0}}),
      .i_shift_out (w_res_shift),
      .i_par_load  (w_res_load),
      .i_par_data  (i_res),
      .o_word      (w_res_word),
      .o_last      (w_res_last)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= LOAD_A;
         r_settle <= '0;
         r_ready  <= 1'b1;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            LOAD_A: begin
               if (w_accept) begin
                  r_busy <= 1'b1;
               end
               if (w_op1_shift && w_op1_last) begin
                  r_state <= LOAD_B;
               end
            end
            LOAD_B: begin
               if (w_op2_shift && w_op2_last) begin
                  r_state  <= CALC;
                  r_ready  <= 1'b0;
                  r_settle <= '0;
               end
            end
            CALC: begin
               // Counter holds at its terminal value until the next CALC entry.
               if (r_settle == c_settle_last) begin
                  r_state <= SEND;
                  r_valid <= 1'b1;
               end else begin
                  r_settle <= r_settle + 1'b1;
               end
            end
            SEND: begin
               if (i_ready && w_res_last) begin
                  r_state <= LOAD_A;
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= LOAD_A;
            end
         endcase
      end
   end

   assign o_ready = r_ready;
   assign o_valid = r_valid;
   assign o_busy  = r_busy;
   assign o_data  = w_res_word[N-1 -: BYTE_W];

endmodule
`default_nettype wire

// File: tb/tb_posit_byte_io_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_posit_byte_io_seq : directed bench for the posit byte-serial I/O block
// Revision: 1.0
// ============================================================================
module tb_posit_byte_io_seq;

   typedef struct {
      logic [31:0] bytes;   // four input bytes, first byte in [31:24]
      logic [15:0] res;
      int          gap;
      logic [15:0] op1;
      logic [15:0] op2;
      logic [7:0]  hi;
      logic [7:0]  lo;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_valid, a_irdy;
   logic [7:0]  a_din;
   logic [15:0] a_res;
   logic        a_ready, a_vout, a_busy;
   logic [7:0]  a_dout;
   logic [15:0] a_op1, a_op2;

   logic        b_rst, b_valid, b_irdy;
   logic [7:0]  b_din;
   logic [15:0] b_res;
   logic        b_ready, b_vout, b_busy;
   logic [7:0]  b_dout;
   logic [15:0] b_op1, b_op2;

   int n_total = 0;
   int n_bad   = 0;

   posit_byte_io_seq #(.N(16), .CALC_CYCLES(1)) dut_a (
      .i_clk(clk), .i_rst(a_rst), .i_data(a_din), .i_valid(a_valid),
      .o_ready(a_ready), .o_data(a_dout), .o_valid(a_vout), .i_ready(a_irdy),
      .o_op_1(a_op1), .o_op_2(a_op2), .i_res(a_res), .o_busy(a_busy)
   );

   posit_byte_io_seq #(.N(16), .CALC_CYCLES(3)) dut_b (
      .i_clk(clk), .i_rst(b_rst), .i_data(b_din), .i_valid(b_valid),
      .o_ready(b_ready), .o_data(b_dout), .o_valid(b_vout), .i_ready(b_irdy),
      .o_op_1(b_op1), .o_op_2(b_op2), .i_res(b_res), .o_busy(b_busy)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one byte after 'gap' idle cycles and hold it until accepted.
   task automatic a_put(input logic [7:0] b, input int gap);
      int w;
      a_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      a_din   = b;
      a_valid = 1'b1;
      w = 0;
      while (!a_ready && w < 20) begin
         tick();
         w++;
      end
      if (w == 20) check("put_timeout", {31'b0, a_ready}, 32'd1);
      tick();
      a_valid = 1'b0;
   endtask

   task automatic a_get(input logic [7:0] exp, input string nm);
      int w;
      a_irdy = 1'b1;
      w = 0;
      while (!a_vout && w < 20) begin
         tick();
         w++;
      end
      check({nm, "_valid"}, {31'b0, a_vout}, 32'd1);
      check({nm, "_data"}, {24'b0, a_dout}, {24'b0, exp});
      check({nm, "_ready_low"}, {31'b0, a_ready}, 32'd0);
      tick();
   endtask

   vec_t        vecs [5];
   logic [7:0]  bb_in [8];
   logic [7:0]  got [4];
   int          acc_at [8];
   int          out_at [4];
   int          idx, nout, w;
   logic        acc, ox;

   initial begin
      vecs[0] = '{32'h12345678, 16'hABCD, 0, 16'h1234, 16'h5678, 8'hAB, 8'hCD};
      vecs[1] = '{32'h12345678, 16'hABCD, 3, 16'h1234, 16'h5678, 8'hAB, 8'hCD};
      vecs[2] = '{32'hFFFF0001, 16'h7FFF, 1, 16'hFFFF, 16'h0001, 8'h7F, 8'hFF};
      vecs[3] = '{32'h00000000, 16'h0000, 0, 16'h0000, 16'h0000, 8'h00, 8'h00};
      vecs[4] = '{32'hA55A8001, 16'h8001, 2, 16'hA55A, 16'h8001, 8'h80, 8'h01};
      bb_in = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

      a_rst = 1'b1; a_valid = 1'b0; a_irdy = 1'b1; a_din = 8'h00; a_res = 16'h0000;
      b_rst = 1'b1; b_valid = 1'b0; b_irdy = 1'b1; b_din = 8'h00; b_res = 16'h0001;
      tick();
      tick();
      check("rst_op1", {16'b0, a_op1}, 32'h0);
      check("rst_op2", {16'b0, a_op2}, 32'h0);
      check("rst_valid", {31'b0, a_vout}, 32'd0);
      check("rst_data", {24'b0, a_dout}, 32'h0);
      check("rst_ready", {31'b0, a_ready}, 32'd1);
      check("rst_busy", {31'b0, a_busy}, 32'd0);
      a_rst = 1'b0;
      b_rst = 1'b0;

      // Table: one full transaction per vector through the CALC_CYCLES=1 unit.
      for (int v = 0; v < 5; v++) begin
         a_res  = vecs[v].res;
         a_irdy = 1'b1;
         for (int i = 0; i < 4; i++) begin
            a_put(vecs[v].bytes[31-8*i -: 8], vecs[v].gap);
            if (i == 0) check($sformatf("v%0d_busy_first", v), {31'b0, a_busy}, 32'd1);
         end
         check($sformatf("v%0d_calc_ready", v), {31'b0, a_ready}, 32'd0);
         check($sformatf("v%0d_calc_valid", v), {31'b0, a_vout}, 32'd0);
         check($sformatf("v%0d_op1", v), {16'b0, a_op1}, {16'b0, vecs[v].op1});
         check($sformatf("v%0d_op2", v), {16'b0, a_op2}, {16'b0, vecs[v].op2});
         tick();
         check($sformatf("v%0d_hi_valid", v), {31'b0, a_vout}, 32'd1);
         check($sformatf("v%0d_hi", v), {24'b0, a_dout}, {24'b0, vecs[v].hi});
         check($sformatf("v%0d_send_ready", v), {31'b0, a_ready}, 32'd0);
         tick();
         check($sformatf("v%0d_lo_valid", v), {31'b0, a_vout}, 32'd1);
         check($sformatf("v%0d_lo", v), {24'b0, a_dout}, {24'b0, vecs[v].lo});
         tick();
         check($sformatf("v%0d_end_valid", v), {31'b0, a_vout}, 32'd0);
         check($sformatf("v%0d_end_busy", v), {31'b0, a_busy}, 32'd0);
         check($sformatf("v%0d_end_ready", v), {31'b0, a_ready}, 32'd1);
      end

      // Output backpressure: i_ready low for 5 cycles in SEND.
      a_res  = 16'hABCD;
      a_irdy = 1'b0;
      a_put(8'h12, 0); a_put(8'h34, 0); a_put(8'h56, 0); a_put(8'h78, 0);
      tick();
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp%0d_valid", k), {31'b0, a_vout}, 32'd1);
         check($sformatf("bp%0d_data", k), {24'b0, a_dout}, 32'hAB);
         check($sformatf("bp%0d_op1", k), {16'b0, a_op1}, 32'h1234);
         check($sformatf("bp%0d_op2", k), {16'b0, a_op2}, 32'h5678);
         tick();
      end
      a_irdy = 1'b1;
      check("bp_hold_data", {24'b0, a_dout}, 32'hAB);
      tick();
      check("bp_lo_valid", {31'b0, a_vout}, 32'd1);
      check("bp_lo_data", {24'b0, a_dout}, 32'hCD);
      tick();
      check("bp_end_valid", {31'b0, a_vout}, 32'd0);

      // Reset after three input bytes, with a handshake offered on the reset edge.
      a_put(8'h12, 0); a_put(8'h34, 0); a_put(8'h56, 0);
      a_rst = 1'b1; a_din = 8'h78; a_valid = 1'b1;
      tick();
      a_rst = 1'b0; a_valid = 1'b0;
      check("mid_rst_op1", {16'b0, a_op1}, 32'h0);
      check("mid_rst_op2", {16'b0, a_op2}, 32'h0);
      check("mid_rst_busy", {31'b0, a_busy}, 32'd0);
      check("mid_rst_ready", {31'b0, a_ready}, 32'd1);
      a_res = 16'h0102;
      a_put(8'hFF, 0); a_put(8'hFF, 0); a_put(8'h00, 0); a_put(8'h01, 0);
      check("fresh_op1", {16'b0, a_op1}, 32'hFFFF);
      check("fresh_op2", {16'b0, a_op2}, 32'h0001);
      a_get(8'h01, "fresh_hi");
      a_get(8'h02, "fresh_lo");

      // Reset while a result byte is waiting drops it.
      a_irdy = 1'b0;
      a_res  = 16'h5555;
      a_put(8'h01, 0); a_put(8'h02, 0); a_put(8'h03, 0); a_put(8'h04, 0);
      tick();
      check("send_pending_valid", {31'b0, a_vout}, 32'd1);
      a_rst = 1'b1;
      tick();
      a_rst = 1'b0;
      check("send_rst_valid", {31'b0, a_vout}, 32'd0);
      check("send_rst_data", {24'b0, a_dout}, 32'h0);
      check("send_rst_ready", {31'b0, a_ready}, 32'd1);

      // Back-to-back: two transactions, i_valid and i_ready always high.
      a_res  = 16'hC3A5;
      a_irdy = 1'b1;
      idx = 0;
      nout = 0;
      for (int cyc = 0; cyc < 40 && nout < 4; cyc++) begin
         a_valid = (idx < 8);
         a_din   = (idx < 8) ? bb_in[idx] : 8'h00;
         acc = a_valid && a_ready;
         ox  = a_vout && a_irdy;
         if (ox) begin
            got[nout]    = a_dout;
            out_at[nout] = cyc;
            nout++;
            if (nout == 1) a_res = 16'h5A3C;
         end
         if (acc) begin
            acc_at[idx] = cyc;
            idx++;
         end
         tick();
      end
      a_valid = 1'b0;
      check("b2b_out_count", nout, 4);
      check("b2b_in_count", idx, 8);
      if (nout == 4 && idx == 8) begin
         check("b2b_out0", {24'b0, got[0]}, 32'hC3);
         check("b2b_out1", {24'b0, got[1]}, 32'hA5);
         check("b2b_out2", {24'b0, got[2]}, 32'h5A);
         check("b2b_out3", {24'b0, got[3]}, 32'h3C);
         check("b2b_restart_cycle", acc_at[4], out_at[1] + 1);
      end
      check("b2b_op1", {16'b0, a_op1}, 32'h0506);
      check("b2b_op2", {16'b0, a_op2}, 32'h0708);

      // Settle latency on the CALC_CYCLES=3 unit.
      b_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b_din = bb_in[i + 4];
         check($sformatf("settle_ready%0d", i), {31'b0, b_ready}, 32'd1);
         tick();
      end
      b_valid = 1'b0;
      w = 0;
      while (!b_vout && w < 10) begin
         tick();
         w++;
         if (w == 2) b_res = 16'h7FFF;
      end
      check("settle_first_xfer_edges", w + 1, 4);
      check("settle_hi", {24'b0, b_dout}, 32'h7F);
      tick();
      check("settle_lo", {24'b0, b_dout}, 32'hFF);
      tick();
      check("settle_end_valid", {31'b0, b_vout}, 32'd0);
      check("settle_end_busy", {31'b0, b_busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
